// File: rtl/seq_det_ctrl.sv
// Overlapping serial pattern detector fed by a valid/ready byte stream (MSB-first).
// Define SEQ_DET_NONOVERLAP_EN to restart the history fill after every match.
module seq_det_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_pat,
    input  logic [3:0]       cfg_len,
    input  logic [CNT_W-1:0] cfg_thresh,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             busy,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_cnt,
    output logic             irq,
    input  logic             irq_clr
);

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t           state;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;
    logic [7:0]       hist;
    logic [3:0]       fill;
    logic [7:0]       pat;
    logic [3:0]       len;
    logic [CNT_W-1:0] thresh;

    logic             hs;
    logic             cfg_ok;
    logic [7:0]       hist_nx;
    logic [3:0]       fill_nx;
    logic [7:0]       mask;
    logic             hit;
    logic             cnt_max;
    logic [CNT_W-1:0] cnt_inc;
    logic             irq_set;
    logic [3:0]       len_clamp;

    always_comb begin
        hs        = s_valid && s_ready;
        cfg_ok    = cfg_we && (state == IDLE) && !hs;
        hist_nx   = {hist[6:0], shreg[bit_idx]};
        fill_nx   = (fill >= 4'd8) ? 4'd8 : fill + 4'd1;
        mask      = 8'((9'd1 << len) - 9'd1);
        hit       = (state == SHIFT) && ((hist_nx & mask) == (pat & mask)) && (fill_nx >= len);
        cnt_max   = &match_cnt;
        cnt_inc   = match_cnt + CNT_W'(1);
        irq_set   = hit && !cnt_max && (thresh != '0) && (cnt_inc == thresh);
        len_clamp = (cfg_len == 4'd0) ? 4'd1 : (cfg_len > 4'd8) ? 4'd8 : cfg_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
            match_pulse <= 1'b0;
            match_cnt   <= '0;
            irq         <= 1'b0;
            shreg       <= '0;
            bit_idx     <= '0;
            hist        <= '0;
            fill        <= '0;
            pat         <= 8'b0000_0111;
            len         <= 4'd3;
            thresh      <= '0;
        end else begin
            match_pulse <= hit;
            case (state)
                IDLE: begin
                    if (hs) begin
                        shreg   <= s_data;
                        bit_idx <= 3'd7;
                        state   <= SHIFT;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                    end else if (cfg_ok) begin
                        pat    <= cfg_pat;
                        len    <= len_clamp;
                        thresh <= cfg_thresh;
                        hist   <= '0;
                        fill   <= '0;
                    end
                end
                SHIFT: begin
                    hist    <= hist_nx;
`ifdef SEQ_DET_NONOVERLAP_EN
                    fill    <= hit ? 4'd0 : fill_nx;
`else
                    fill    <= fill_nx;
`endif
                    bit_idx <= bit_idx - 3'd1;
                    // s_ready is registered, so it rises one cycle ahead of the last bit
                    s_ready <= (bit_idx == 3'd1);
                    if (bit_idx == 3'd0) begin
                        if (hs) begin
                            shreg   <= s_data;
                            bit_idx <= 3'd7;
                            s_ready <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            s_ready <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (cfg_ok)
                match_cnt <= '0;
            else if (hit && !cnt_max)
                match_cnt <= cnt_inc;

            if (irq_set)
                irq <= 1'b1;
            else if (irq_clr || cfg_ok)
                irq <= 1'b0;
        end
    end

endmodule
